// File: rtl/mux_tree_pipe_pkg.sv
// mux_pkg: shared radix, log4 helper and power-of-4 check for the pipelined mux tree.
package mux_pkg;
  localparam int MUX_RADIX = 4;
  function automatic int clog4(input int n);
    int l = 0;
    for (int v = 1; v < n; v *= MUX_RADIX) l++;
    return l;
  endfunction
  function automatic bit is_pow4(input int n);
    return n >= MUX_RADIX && (MUX_RADIX ** clog4(n)) == n;
  endfunction
endpackage

// File: rtl/mux_tree_pipe_mux4_stage.sv
// mux4_stage: one registered 4:1 slice carrying its valid bit.
module mux4_stage #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DATA_W-1:0] in,
  input  logic [1:0]          sel,
  input  logic                vld_in,
  output logic [DATA_W-1:0]   out,
  output logic                vld_out
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out     <= '0;
      vld_out <= 1'b0;
    end else begin
      out     <= in[sel*DATA_W +: DATA_W];
      vld_out <= vld_in;
    end
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N:1 radix-4 mux tree with round-robin scan pointer.
// MUX_TREE_HOLD_LAST_EN: outputs hold the last valid result instead of zeroing.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_IN   = 16,
  localparam int LEVELS = clog4(N_IN),
  localparam int SEL_W  = 2 * LEVELS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic                   in_valid,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   scan_en,
  input  logic                   scan_clr,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       out_sel,
  output logic [SEL_W-1:0]       scan_ptr
);
  if (!is_pow4(N_IN)) begin : g_bad_n
    $error("mux_tree_pipe: N_IN=%0d must be a power of 4 and at least 4", N_IN);
  end
  logic [SEL_W-1:0]       eff_sel;
  logic [SEL_W-1:0]       sel_q [LEVELS];
  logic [N_IN*DATA_W-1:0] lvl_d [LEVELS];
  logic [LEVELS-1:0]      lvl_v;
  logic [DATA_W-1:0]      fin_d;
  logic                   fin_v;
  assign eff_sel = scan_en ? scan_ptr : sel;
  // Row j narrows the channel count by four; sel_q[j-1] is the select captured j cycles ago.
  for (genvar j = 0; j < LEVELS; j++) begin : g_row
    localparam int CNT = N_IN >> (2 * (j + 1));
    logic [4*CNT*DATA_W-1:0] src;
    logic [1:0]              s;
    logic                    v_in;
    logic [CNT-1:0]          v;
    if (j == 0) begin : g_head
      assign src  = in_data;
      assign s    = eff_sel[1:0];
      assign v_in = in_valid;
    end else begin : g_tail
      assign src  = lvl_d[j-1][4*CNT*DATA_W-1:0];
      assign s    = sel_q[j-1][2*j+1:2*j];
      assign v_in = lvl_v[j-1];
    end
    for (genvar i = 0; i < CNT; i++) begin : g_col
      mux4_stage #(.DATA_W(DATA_W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (src[i*4*DATA_W +: 4*DATA_W]),
        .sel     (s),
        .vld_in  (v_in),
        .out     (lvl_d[j][i*DATA_W +: DATA_W]),
        .vld_out (v[i])
      );
    end
    assign lvl_d[j][N_IN*DATA_W-1:CNT*DATA_W] = '0;
    assign lvl_v[j] = v[0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sel_q <= '{default: '0};
    else begin
      sel_q[0] <= eff_sel;
      for (int k = 1; k < LEVELS; k++) sel_q[k] <= sel_q[k-1];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) scan_ptr <= '0;
    else if (scan_clr) scan_ptr <= '0;
    else if (scan_en && in_valid) scan_ptr <= scan_ptr + 1'b1;
  assign fin_d     = lvl_d[LEVELS-1][DATA_W-1:0];
  assign fin_v     = lvl_v[LEVELS-1];
  assign out_valid = fin_v;
`ifdef MUX_TREE_HOLD_LAST_EN
  logic [DATA_W-1:0] last_d;
  logic [SEL_W-1:0]  last_s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_d <= '0;
      last_s <= '0;
    end else if (fin_v) begin
      last_d <= fin_d;
      last_s <= sel_q[LEVELS-1];
    end
  assign out_data = fin_v ? fin_d : last_d;
  assign out_sel  = fin_v ? sel_q[LEVELS-1] : last_s;
`else
  assign out_data = fin_v ? fin_d : '0;
  assign out_sel  = sel_q[LEVELS-1];
`endif
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: random and directed checks of 16- and 64-input trees against a sample-history model.
module tb_mux_tree_pipe;
  typedef struct { bit v; int s; int d; } samp_t;
`ifdef MUX_TREE_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] in_data;
  logic         in_valid;
  logic [5:0]   sel;
  logic         scan_en;
  logic         scan_clr;
  logic [7:0]   od [2];
  logic         ov [2];
  logic [5:0]   os [2];
  logic [5:0]   sp [2];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int N  = g ? 64 : 16;
    localparam int LV = g ? 3 : 2;
    localparam int SW = 2 * LV;
    logic [SW-1:0] o_sel, o_ptr;
    samp_t h [4];
    samp_t e;
    int ptr, last_d, last_s, es, xd, xs;
    mux_tree_pipe #(.DATA_W(8), .N_IN(N)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[N*8-1:0]),
      .in_valid (in_valid),
      .sel      (sel[SW-1:0]),
      .scan_en  (scan_en),
      .scan_clr (scan_clr),
      .out_data (od[g]),
      .out_valid(ov[g]),
      .out_sel  (o_sel),
      .scan_ptr (o_ptr)
    );
    assign os[g] = 6'(o_sel);
    assign sp[g] = 6'(o_ptr);
    // Model: history of captured samples; output shows the one LV-1 captures back.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) h[i] = '{1'b0, 0, 0};
        ptr = 0; last_d = 0; last_s = 0;
      end else begin
        es = scan_en ? ptr : int'(sel) % N;
        for (int i = 3; i > 0; i--) h[i] = h[i-1];
        h[0] = '{in_valid, es, int'(in_data[es*8 +: 8])};
        ptr = scan_clr ? 0 : (scan_en && in_valid) ? (ptr + 1) % N : ptr;
        if (h[LV-1].v) begin
          last_d = h[LV-1].d;
          last_s = h[LV-1].s;
        end
      end
    end
    always @(negedge clk) begin
      e  = h[LV-1];
      xd = e.v ? e.d : HOLD ? last_d : 0;
      xs = (HOLD && !e.v) ? last_s : e.s;
      checks++;
      if (int'(od[g]) != xd || ov[g] != e.v || int'(os[g]) != xs || int'(sp[g]) != ptr) begin
        errors++;
        $display("FAIL model_n%0d t=%0t data got %0h exp %0h valid got %b exp %b sel got %0d exp %0d ptr got %0d exp %0d",
                 N, $time, od[g], xd, ov[g], e.v, os[g], xs, sp[g], ptr);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", nm, $time, act, exp);
    end
  endtask
  task automatic rand_data();
    for (int w = 0; w < 16; w++) in_data[w*32 +: 32] = $urandom();
  endtask
  task automatic ramp_data();
    for (int k = 0; k < 64; k++) in_data[k*8 +: 8] = 8'(16 + k);
  endtask
  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; sel = '0; scan_en = 1'b0; scan_clr = 1'b0; in_data = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      in_valid = 1'(($urandom() & 1));
      sel = 6'($urandom());
      scan_en = 1'(($urandom() & 1));
      cyc();
    end
    chk("rst_data", od[0], 0); chk("rst_valid", ov[0], 0);
    chk("rst_sel", os[0], 0); chk("rst_ptr", sp[0], 0); chk("rst_valid64", ov[1], 0);
    in_valid = 1'b0; scan_en = 1'b0; sel = '0;
    rst_n = 1'b1;
    cyc();
    ramp_data();
    in_valid = 1'b1; sel = 0; cyc();
    sel = 5; cyc();
    chk("dir_d0", od[0], 'h10); chk("dir_s0", os[0], 0); chk("lat3_not_yet", ov[1], 0);
    sel = 15; cyc();
    chk("dir_d1", od[0], 'h15); chk("dir_s1", os[0], 5); chk("lat3_d0", od[1], 'h10);
    in_valid = 1'b0; cyc();
    chk("dir_d2", od[0], 'h1F); chk("dir_s2", os[0], 15); chk("lat3_d1", od[1], 'h15);
    cyc();
    chk("inv_valid", ov[0], 0); chk("inv_data", od[0], HOLD ? 'h1F : 0); chk("lat3_d2", od[1], 'h1F);
    cyc();
    scan_en = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      rand_data();
      cyc();
      if (i == 15) chk("wrap_ptr15", sp[0], 15);
      if (i == 16) begin chk("wrap_ptr0", sp[0], 0); chk("ptr64_16", sp[1], 16); end
      if (i == 17) chk("wrap_sel15", os[0], 15);
      if (i == 18) chk("wrap_sel0", os[0], 0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_data(); cyc(); end
    chk("hold_ptr", sp[0], 2); chk("hold_ptr64", sp[1], 18); chk("hold_valid", ov[0], 0);
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin rand_data(); cyc(); end
    chk("pre_clr_ptr", sp[0], 9);
    scan_clr = 1'b1; rand_data(); cyc();
    chk("clr_ptr", sp[0], 0); chk("clr_ptr64", sp[1], 0);
    scan_clr = 1'b0; rand_data(); cyc();
    chk("clr_old_sel", os[0], 9);
    rand_data(); cyc();
    chk("clr_old_sel64", os[1], 25);
    sel = 3;
    for (int i = 0; i < 10; i++) begin
      scan_en = 1'(i & 1);
      rand_data();
      cyc();
    end
    scan_en = 1'b0; ramp_data();
    in_valid = 1'b1; sel = 7; cyc();
    in_valid = 1'b0; sel = 2; cyc();
    chk("feat_d0", od[0], 'h17);
    cyc();
    chk("feat_inv", od[0], HOLD ? 'h17 : 0);
    in_valid = 1'b1; sel = 9; cyc();
    chk("feat_inv64", od[1], HOLD ? 'h17 : 0);
    in_valid = 1'b0; cyc();
    chk("feat_d1", od[0], 'h19);
    cyc(); cyc();
    for (int i = 0; i < 400; i++) begin
      rand_data();
      in_valid = ($urandom_range(0, 3) != 0);
      sel = 6'($urandom());
      scan_en = 1'(($urandom() & 1));
      scan_clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    scan_clr = 1'b0; in_valid = 1'b1;
    cyc(); cyc(); cyc();
    chk("pre_arst_valid", ov[0], 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", ov[0], 0); chk("arst_data", od[0], 0);
    chk("arst_ptr", sp[0], 0); chk("arst_valid64", ov[1], 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer built as a tree of registered radix-4 stages.
- Each input is DATA_W bits wide. A valid bit and the effective select travel alongside the data.
- Includes an auto-scan mode: an internal pointer steps through all inputs round-robin.
- Replaces flat combinational muxes in channel-select and monitor paths where timing needs one register per tree level.

Parameters:
- DATA_W, 8, width of each input channel and of out_data.
- N_IN, 16, number of input channels. Must be a power of 4 and at least 4; elaboration error otherwise.
- SEL_W, log2(N_IN), select width. Derived; not to be overridden.
- LEVELS, log4(N_IN), number of radix-4 stages, which equals the latency. Derived.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N_IN*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W]
- in_valid  input  1  qualifies in_data and sel in this cycle
- sel  input  SEL_W  channel select; used when scan_en=0
- scan_en  input  1  1 = select from the internal scan pointer instead of sel
- scan_clr  input  1  synchronous clear of the scan pointer to 0
- out_data  output  DATA_W  selected channel, LEVELS cycles after capture
- out_valid  output  1  delayed in_valid
- out_sel  output  SEL_W  effective select that produced out_data
- scan_ptr  output  SEL_W  current scan pointer value

Behaviour:
- Reset (async assert, sync release): all stage registers 0, out_data=0, out_valid=0, out_sel=0, scan_ptr=0.
- Effective select: eff_sel = scan_en ? scan_ptr : sel, evaluated combinationally in the capture cycle.
- Tree structure:
  - Stage 0 groups inputs in fours by eff_sel[1:0] and registers N_IN/4 results.
  - Stage j selects among groups of four using eff_sel[2j+1:2j], taken from the select copy pipelined with that stage.
  - The final stage drives out_data.
- Latency: exactly LEVELS cycles from in_valid=1 to out_valid=1 (N_IN=16 gives 2; N_IN=64 gives 3).
- Throughput: one result per cycle. No backpressure; the pipeline always advances.
- Valid and select copies shift with the data every cycle. out_sel equals the eff_sel captured with the same sample.
- Invalid samples:
  - in_valid=0: the stage still registers data but the valid bit is 0.
  - out_data on invalid cycles depends on the optional feature.
- Scan pointer:
  - Advances by 1 on each cycle with scan_en=1 and in_valid=1.
  - Wraps N_IN-1 -> 0.
  - Holds when scan_en=0 or in_valid=0.
  - scan_clr=1 forces scan_ptr to 0 next cycle and overrides advance. The current cycle still uses the old pointer.
- Mode switch mid-stream: samples already in flight keep their captured select. There is no flush and no bubble.
- Reset mid-operation: in-flight samples are discarded and out_valid drops immediately.

Optional Feature:
- Macro MUX_TREE_HOLD_LAST_EN.
- Defined: out_data and out_sel update only when the final-stage valid is 1; otherwise they hold the last valid value (0 after reset).
- Undefined: out_data is forced to 0 whenever out_valid=0, and out_sel follows the pipeline unconditionally.

Decomposition:
- Shared package mux_pkg holds:
  - function clog4(n) for LEVELS;
  - localparam MUX_RADIX=4;
  - a compile-time check helper for the power-of-4 rule.
- Sub-module mux4_stage: one registered 4:1 slice with parameter DATA_W. Ports: clk, rst_n, in[4*DATA_W], sel[1:0], vld_in, out, vld_out.
- The top level generates LEVELS rows of mux4_stage instances, plus the select/valid shift registers and the scan counter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs -> out_data=0, out_valid=0, out_sel=0, scan_ptr=0. Assert rst_n asynchronously mid-cycle -> outputs clear before the next edge.
- Directed select, N_IN=16, DATA_W=8, channel k = 8'h10+k: sel=0,5,15 on consecutive valid cycles -> out_data 8'h10, 8'h15, 8'h1F on cycles 2,3,4 with out_sel 0,5,15.
- Scan wrap: scan_en=1, in_valid=1 for 18 cycles -> out_sel sequence 0..15,0,1 with latency 2; scan_ptr shows 15->0 wrap.
- Scan hold and clear:
  - in_valid=0 for 3 cycles mid-scan -> scan_ptr frozen, out_valid=0 for those slots.
  - scan_clr=1 at ptr=9 -> next ptr 0; that cycle's sample still uses 9.
- Mode switch: alternate scan_en 0/1 every cycle with sel=3 -> out_sel alternates 3 and the scan value, with no lost or duplicated samples.
- Feature check, valid pattern 1,0,0,1:
  - With MUX_TREE_HOLD_LAST_EN: out_data holds during invalid slots.
  - Without: out_data=0 during invalid slots.
  - Repeat with N_IN=64: latency 3.
